// File: rtl/mux_nto1_scan.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mux_nto1_scan
//
// Registered N-to-1 word selector with a manual mode (host drives the select)
// and an auto-scan mode (an internal sequencer visits every channel, dwelling
// DWELL update cycles on each). The output word f and its channel tag ch are
// written on the same edge, so they always describe the same input word.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           block enable; 0 = idle, f/ch held
//   mode         0 = manual select, 1 = auto-scan
//   s            manual channel select
//   w            flattened inputs, channel k at w[k*WIDTH +: WIDTH]
//   f            registered selected word
//   ch           channel index of the word currently on f
//   valid        high for the cycle after an update edge (en was 1)
//   wrap         one-cycle pulse when the scan steps from CH-1 back to 0
//   err          one-cycle pulse when a manual select s >= CH was rejected
//   o_dbg_state  current sequencer state (IDLE/MANUAL/SCAN) for observation
//
// Handshake: there is no back-pressure. valid=1 means f/ch were refreshed on
// the last edge; the consumer must take the word in that cycle or lose it.
// ---------------------------------------------------------------------------
module mux_nto1_scan #(
    parameter int WIDTH = 3,
    parameter int CH    = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      s,
    input  logic [CH*WIDTH-1:0]   w,
    output logic [WIDTH-1:0]      f,
    output logic [SEL_W-1:0]      ch,
    output logic                  valid,
    output logic                  wrap,
    output logic                  err,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Channel count in SEL_W+1 bits so CH = 2**SEL_W is representable.
    localparam logic [SEL_W:0] CH_LIM     = (SEL_W+1)'(CH);
    localparam logic [7:0]     DWELL_LAST = 8'(DWELL - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_dcnt;
    logic [7:0]       w_dcnt_nxt;
    logic [SEL_W-1:0] w_ch_nxt;
    logic [SEL_W:0]   w_ch_inc;
    logic             w_wrap_nxt;
    logic             w_err_nxt;

    // One extra bit so ch+1 cannot overflow before the wrap compare.
    assign w_ch_inc    = {1'b0, ch} + (SEL_W+1)'(1);
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = ch;
        w_dcnt_nxt  = r_dcnt;
        w_wrap_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        if (!en) begin
            // Idle keeps channel and dwell position so a resumed scan
            // continues where it stopped.
            w_state_nxt = IDLE;
        end else if (!mode) begin
            w_state_nxt = MANUAL;
            w_dcnt_nxt  = '0;
            if ({1'b0, s} < CH_LIM) begin
                w_ch_nxt = s;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else begin
            w_state_nxt = SCAN;
            if (r_state == MANUAL) begin
                // Coming from manual: restart the dwell on the current
                // channel so it gets a full DWELL.
                w_dcnt_nxt = '0;
            end else if (r_dcnt >= DWELL_LAST) begin
                w_dcnt_nxt = '0;
                if (w_ch_inc == CH_LIM) begin
                    w_ch_nxt   = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_ch_nxt = w_ch_inc[SEL_W-1:0];
                end
            end else begin
                w_dcnt_nxt = r_dcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
            f       <= '0;
            ch      <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            valid   <= en;
            wrap    <= w_wrap_nxt;
            err     <= w_err_nxt;
            if (en) begin
                ch <= w_ch_nxt;
                f  <= w[int'(w_ch_nxt)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_scan.sv
`timescale 1ns/1ps
module tb_mux_nto1_scan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic       mode;
  logic [1:0] s;

  // instance a: WIDTH=3, CH=4, DWELL=5 ; instance b: WIDTH=4, CH=3, DWELL=2
  logic [2:0]  wa[4];
  logic [3:0]  wb[3];
  logic [11:0] w_a;
  logic [11:0] w_b;
  assign w_a = {wa[3], wa[2], wa[1], wa[0]};
  assign w_b = {wb[2], wb[1], wb[0]};

  logic [2:0] f_a;
  logic [1:0] ch_a;
  logic       valid_a, wrap_a, err_a;
  logic [1:0] dbg_a;
  logic [3:0] f_b;
  logic [1:0] ch_b;
  logic       valid_b, wrap_b, err_b;
  logic [1:0] dbg_b;

  mux_nto1_scan #(.WIDTH(3), .CH(4), .SEL_W(2), .DWELL(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .w(w_a),
    .f(f_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a), .err(err_a),
    .o_dbg_state(dbg_a)
  );

  mux_nto1_scan #(.WIDTH(4), .CH(3), .SEL_W(2), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .s(s), .w(w_b),
    .f(f_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b), .err(err_b),
    .o_dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: which channel is shown, how many dwell steps were spent on
  // it, and what the block was doing last cycle (0 idle, 1 manual, 2 scan).
  int m_ch[2], m_pos[2], m_act[2], m_f[2], m_valid[2], m_wrap[2], m_err[2];

  function automatic int nch(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int dwell(input int k);
    return (k == 0) ? 5 : 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ch[k] = 0; m_pos[k] = 0; m_act[k] = 0; m_f[k] = 0;
      m_valid[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      m_err[k]  = 0;
      if (!en) begin
        m_valid[k] = 0;
        m_act[k]   = 0;
      end else begin
        m_valid[k] = 1;
        if (!mode) begin
          if (int'(s) < nch(k)) m_ch[k] = int'(s);
          else m_err[k] = 1;
          m_pos[k] = 0;
          m_act[k] = 1;
        end else begin
          if (m_act[k] == 1) begin
            m_pos[k] = 0;
          end else if (m_pos[k] == dwell(k) - 1) begin
            m_pos[k] = 0;
            m_ch[k]  = (m_ch[k] + 1) % nch(k);
            m_wrap[k] = (m_ch[k] == 0) ? 1 : 0;
          end else begin
            m_pos[k]++;
          end
          m_act[k] = 2;
        end
        m_f[k] = (k == 0) ? int'(wa[m_ch[k]]) : int'(wb[m_ch[k]]);
      end
    end
  endtask

  task automatic check_all();
    chk("f_a",     32'(f_a),     32'(m_f[0]));
    chk("ch_a",    32'(ch_a),    32'(m_ch[0]));
    chk("valid_a", 32'(valid_a), 32'(m_valid[0]));
    chk("wrap_a",  32'(wrap_a),  32'(m_wrap[0]));
    chk("err_a",   32'(err_a),   32'(m_err[0]));
    chk("f_b",     32'(f_b),     32'(m_f[1]));
    chk("ch_b",    32'(ch_b),    32'(m_ch[1]));
    chk("valid_b", 32'(valid_b), 32'(m_valid[1]));
    chk("wrap_b",  32'(wrap_b),  32'(m_wrap[1]));
    chk("err_b",   32'(err_b),   32'(m_err[1]));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after the edge; outputs are compared at that point.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic rand_w();
    for (int i = 0; i < 4; i++) wa[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) wb[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1'b1;
  endtask

  task automatic set_const_w();
    for (int i = 0; i < 4; i++) wa[i] = 3'(i + 1);
    for (int i = 0; i < 3; i++) wb[i] = 4'(i + 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; s = 2'd0;
    for (int i = 0; i < 4; i++) wa[i] = '0;
    for (int i = 0; i < 3; i++) wb[i] = '0;
    model_reset();
    #2 check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // manual select, inputs incremented every cycle
    en = 1'b1; mode = 1'b0;
    set_const_w();
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      cycle();
      for (int j = 0; j < 4; j++) wa[j] = wa[j] + 3'd1;
      for (int j = 0; j < 3; j++) wb[j] = wb[j] + 4'd1;
    end

    // async reset with f = 3'b101 on the output
    wa[1] = 3'd5; s = 2'd1;
    cycle();
    chk("f_a_pre_reset", 32'(f_a), 32'd5);
    en = 1'b0;
    async_reset_pulse();
    repeat (3) cycle();

    // scan with constant inputs through a full rotation
    set_const_w();
    en = 1'b1; mode = 1'b1;
    repeat (24) cycle();

    // mode switch in the middle of a dwell
    begin
      int guard = 0;
      while (!(m_ch[0] == 2 && m_pos[0] == 3) && guard < 40) begin
        cycle();
        guard++;
      end
      if (guard >= 40) chk("wait_mode_switch", 32'd0, 32'd1);
    end
    mode = 1'b0; s = 2'd1;
    cycle();
    mode = 1'b1;
    repeat (8) cycle();

    // enable gating mid-dwell
    begin
      int guard = 0;
      while (!(m_ch[0] == 1 && m_pos[0] == 2) && guard < 60) begin
        cycle();
        guard++;
      end
      if (guard >= 60) chk("wait_enable_gate", 32'd0, 32'd1);
    end
    en = 1'b0;
    repeat (4) cycle();
    en = 1'b1;
    repeat (6) cycle();

    // out-of-range manual select on the 3-channel instance
    mode = 1'b0;
    s = 2'd1; cycle();
    s = 2'd3; cycle();
    s = 2'd2; cycle();
    s = 2'd3; cycle();
    mode = 1'b1;
    repeat (10) cycle();

    // randomized traffic
    repeat (400) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 5) == 0) ? ~mode : mode;
      s    = 2'($urandom_range(0, 3));
      rand_w();
      cycle();
      if ($urandom_range(0, 99) == 0) async_reset_pulse();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
